// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data accesses.
// One transaction in flight; data wins arbitration, a watchdog aborts stuck accesses.
module mem_port_arbiter #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_valid,
   output logic [31:0] if_rdata,
   output logic        if_stall,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [1:0]  d_size,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_valid,
   output logic [31:0] d_rdata,
   output logic        d_stall,
   output logic        bus_err,
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [3:0]  m_be,
   output logic [31:0] m_wdata,
   input  logic        m_ack,
   input  logic [31:0] m_rdata
);

   typedef enum logic [1:0] {IDLE, DATA, FETCH, DONE} state_t;

   localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   state_t          state_q;
   logic [WD_W-1:0] wd_q;
   logic            m_req_q;
   logic            m_we_q;
   logic [31:0]     m_addr_q;
   logic [3:0]      m_be_q;
   logic [31:0]     m_wdata_q;
   logic            if_valid_q;
   logic            d_valid_q;
   logic            bus_err_q;
   logic [31:0]     if_rdata_q;
   logic [31:0]     d_rdata_q;

   logic            misaligned_d;
   logic [3:0]      be_d;
   logic [31:0]     wdata_d;
   logic            wd_expire_d;

   always_comb begin
      misaligned_d = 1'b0;
      be_d         = 4'b1111;
      case (d_size)
         2'b00: be_d = 4'b0001 << d_addr[1:0];
         2'b01: begin
            be_d         = 4'b0011 << d_addr[1:0];
            misaligned_d = d_addr[0];
         end
         2'b10:   misaligned_d = (d_addr[1:0] != 2'b00);
         default: misaligned_d = 1'b1;
      endcase
      wdata_d     = d_wdata << {d_addr[1:0], 3'b000};
      // Expire on the TIMEOUT-th busy cycle without an ack; an ack in that cycle still wins.
      wd_expire_d = (TIMEOUT != 0) && (int'(wd_q) + 1 == TIMEOUT);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wd_q       <= '0;
         m_req_q    <= 1'b0;
         m_we_q     <= 1'b0;
         m_addr_q   <= '0;
         m_be_q     <= '0;
         m_wdata_q  <= '0;
         if_valid_q <= 1'b0;
         d_valid_q  <= 1'b0;
         bus_err_q  <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         if_valid_q <= 1'b0;
         d_valid_q  <= 1'b0;
         bus_err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (d_req) begin
                  if (misaligned_d) begin
                     d_valid_q <= 1'b1;
                     bus_err_q <= 1'b1;
                     d_rdata_q <= '0;
                     state_q   <= DONE;
                  end else begin
                     m_req_q   <= 1'b1;
                     m_we_q    <= d_we;
                     m_addr_q  <= d_addr & 32'hFFFF_FFFC;
                     m_be_q    <= be_d;
                     m_wdata_q <= wdata_d;
                     wd_q      <= '0;
                     state_q   <= DATA;
                  end
               end else if (if_req) begin
                  m_req_q   <= 1'b1;
                  m_we_q    <= 1'b0;
                  m_addr_q  <= if_addr & 32'hFFFF_FFFC;
                  m_be_q    <= 4'b1111;
                  m_wdata_q <= '0;
                  wd_q      <= '0;
                  state_q   <= FETCH;
               end
            end
            DATA, FETCH: begin
               if (m_ack || wd_expire_d) begin
                  m_req_q <= 1'b0;
                  m_we_q  <= 1'b0;
                  state_q <= DONE;
                  if (!m_ack) bus_err_q <= 1'b1;
                  if (state_q == DATA) begin
                     d_valid_q <= 1'b1;
                     d_rdata_q <= m_ack ? m_rdata : 32'd0;
                  end else begin
                     if_valid_q <= 1'b1;
                     if_rdata_q <= m_ack ? m_rdata : 32'd0;
                  end
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign if_valid = if_valid_q;
   assign if_rdata = if_rdata_q;
   assign d_valid  = d_valid_q;
   assign d_rdata  = d_rdata_q;
   assign bus_err  = bus_err_q;
   assign m_req    = m_req_q;
   assign m_we     = m_we_q;
   assign m_addr   = m_addr_q;
   assign m_be     = m_be_q;
   assign m_wdata  = m_wdata_q;
   assign if_stall = if_req & ~if_valid_q;
   assign d_stall  = d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed and random transactions checked against a
// transaction-level reference (expected latency, enables, data and error per request).
module tb_mem_port_arbiter;

   localparam int TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_valid;
   logic [31:0] if_rdata;
   logic        if_stall;
   logic        d_req;
   logic        d_we;
   logic [1:0]  d_size;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_valid;
   logic [31:0] d_rdata;
   logic        d_stall;
   logic        bus_err;
   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [3:0]  m_be;
   logic [31:0] m_wdata;
   logic        m_ack;
   logic [31:0] m_rdata;

   int errors = 0;
   int checks = 0;

   mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
      .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_valid(d_valid), .d_rdata(d_rdata), .d_stall(d_stall), .bus_err(bus_err),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
      .m_ack(m_ack), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [3:0] be_ref(input logic [1:0] sz, input logic [31:0] a);
      int off;
      off = int'(a % 4);
      case (sz)
         2'd0:    return 4'(1 << off);
         2'd1:    return 4'(3 << off);
         default: return 4'hF;
      endcase
   endfunction

   function automatic bit bad_ref(input logic [1:0] sz, input logic [31:0] a);
      return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
   endfunction

   // One request from an idle arbiter; wait_c = ack on that m_req cycle (0-based), <0 never acks.
   task automatic run_txn(input bit is_d, input bit we, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int wait_c, input bit hold);
      bit          bad, tmo, got;
      int          exp_mcyc, exp_vidx, mcnt;
      logic [31:0] exp_rd;
      logic [3:0]  exp_be_v;
      logic        own_v, oth_v, own_st, oth_st;
      logic [31:0] own_rd;
      bad      = is_d && bad_ref(sz, a);
      tmo      = !bad && (wait_c < 0 || wait_c >= TIMEOUT);
      exp_mcyc = bad ? 0 : (tmo ? TIMEOUT : wait_c + 1);
      exp_vidx = exp_mcyc + 1;
      exp_rd   = (bad || tmo) ? 32'd0 : rd;
      exp_be_v = is_d ? be_ref(sz, a) : 4'hF;
      d_req = is_d; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
      if_req = !is_d || hold; if_addr = a;
      mcnt = 0; got = 0;
      for (int idx = 1; idx <= TIMEOUT + 10 && !got; idx++) begin
         @(negedge clk);
         own_v  = is_d ? d_valid : if_valid;
         oth_v  = is_d ? if_valid : d_valid;
         own_rd = is_d ? d_rdata : if_rdata;
         own_st = is_d ? d_stall : if_stall;
         oth_st = is_d ? if_stall : d_stall;
         if (m_req) begin
            mcnt++;
            chk("m_addr", m_addr, a & 32'hFFFF_FFFC);
            chk("m_be", {28'd0, m_be}, {28'd0, exp_be_v});
            chk("m_we", {31'd0, m_we}, {31'd0, is_d & we});
            if (is_d && we) chk("m_wdata", m_wdata, wd << (8 * (a % 4)));
            m_ack   = (mcnt - 1 == wait_c);
            m_rdata = m_ack ? rd : $urandom;
         end else begin
            m_ack   = 1'b0;
            m_rdata = $urandom;
         end
         chk("other_valid", {31'd0, oth_v}, 32'd0);
         chk("own_stall", {31'd0, own_st}, {31'd0, idx != exp_vidx});
         chk("other_stall", {31'd0, oth_st}, {31'd0, hold});
         if (own_v) begin
            got = 1;
            chk("valid_latency", idx, exp_vidx);
            chk("rdata", own_rd, exp_rd);
            chk("bus_err", {31'd0, bus_err}, {31'd0, bad || tmo});
            chk("m_req_cycles", mcnt, exp_mcyc);
            d_req = 1'b0;
            if (!is_d) if_req = 1'b0;
            m_ack = 1'($urandom % 2);   // stray ack during the bubble
         end else begin
            chk("bus_err_quiet", {31'd0, bus_err}, 32'd0);
         end
      end
      chk("valid_seen", {31'd0, got}, 32'd1);
      @(negedge clk);
      chk("valid_pulse_end", {31'd0, is_d ? d_valid : if_valid}, 32'd0);
      chk("m_req_after", {31'd0, m_req}, 32'd0);
      m_ack = 1'b0;
      $display("txn %s we=%0d size=%0d addr=%h wait=%0d hold=%0d err=%0d", is_d ? "data " : "fetch",
               we, sz, a, wait_c, hold, bad || tmo);
   endtask

   initial begin
      bit          is_d, hold;
      logic [1:0]  sz;
      rst_n = 1'b0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_size = 0;
      d_addr = 0; d_wdata = 0; m_ack = 0; m_rdata = 0;
      repeat (2) @(negedge clk);
      chk("rst_m_req", {31'd0, m_req}, 32'd0);
      chk("rst_m_addr", m_addr, 32'd0);
      chk("rst_valids", {30'd0, if_valid, d_valid}, 32'd0);
      chk("rst_rdata", if_rdata | d_rdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases from the plan plus alignment and watchdog boundaries
      run_txn(1, 0, 2'b10, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 0, 0);
      run_txn(1, 1, 2'b00, 32'h0000_0203, 32'h0000_00A5, 32'h0, 1, 0);
      run_txn(1, 1, 2'b01, 32'h0000_0302, 32'h0000_BEEF, 32'h0, 0, 0);
      run_txn(1, 0, 2'b10, 32'h0000_0102, 32'h0, 32'h1111_1111, 0, 0);
      run_txn(1, 1, 2'b01, 32'h0000_0101, 32'h0000_1234, 32'h0, 0, 0);
      run_txn(1, 0, 2'b11, 32'h0000_0100, 32'h0, 32'h0, 0, 0);
      run_txn(1, 0, 2'b10, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 2, 1);   // conflict: data first
      run_txn(0, 0, 2'b10, 32'h0000_1000, 32'h0, 32'h1357_9BDF, 2, 0);   // then the held fetch
      run_txn(0, 0, 2'b10, 32'h0000_2000, 32'h0, 32'h0BAD_CAFE, TIMEOUT - 1, 0);
      run_txn(0, 0, 2'b10, 32'h0000_3000, 32'h0, 32'h5555_AAAA, -1, 0);

      // Stray acks with nothing in flight must produce nothing
      for (int k = 0; k < 3; k++) begin
         m_ack = 1'b1; m_rdata = $urandom;
         @(negedge clk);
         chk("stray_ack_valid", {30'd0, if_valid, d_valid}, 32'd0);
         chk("stray_ack_m_req", {31'd0, m_req}, 32'd0);
      end
      m_ack = 1'b0;
      @(negedge clk);

      for (int n = 0; n < 24; n++) begin
         is_d = ($urandom % 3) != 0;
         sz   = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
         hold = is_d && ($urandom % 3 == 0);
         run_txn(is_d, 1'($urandom % 2), sz, $urandom, $urandom, $urandom, int'($urandom % 4), hold);
         if (hold) run_txn(0, 0, 2'b10, $urandom, 32'h0, $urandom, int'($urandom % 4), 0);
      end

      // Reset in the middle of a data wait aborts silently
      d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 32'h0000_0500; d_wdata = 32'h89AB_CDEF;
      repeat (3) @(negedge clk);
      chk("pre_rst_m_req", {31'd0, m_req}, 32'd1);
      rst_n = 1'b0; d_req = 1'b0;
      @(negedge clk);
      chk("mid_rst_m_req", {31'd0, m_req}, 32'd0);
      chk("mid_rst_m_we", {31'd0, m_we}, 32'd0);
      chk("mid_rst_m_addr", m_addr, 32'd0);
      chk("mid_rst_m_be", {28'd0, m_be}, 32'd0);
      chk("mid_rst_m_wdata", m_wdata, 32'd0);
      chk("mid_rst_flags", {29'd0, if_valid, d_valid, bus_err}, 32'd0);
      chk("mid_rst_rdata", if_rdata | d_rdata, 32'd0);
      rst_n = 1'b1; m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("late_ack_valid", {31'd0, d_valid}, 32'd0);
      m_ack = 1'b0;
      @(negedge clk);
      chk("late_ack_valid2", {31'd0, d_valid}, 32'd0);
      chk("late_ack_m_req", {31'd0, m_req}, 32'd0);
      chk("late_ack_rdata", d_rdata, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
